// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encodings and default timing constants for switch debouncing
//
// Purpose : common definitions for switch_debounce and related board-input conditioning.
// Contents: state_t         - 2-bit filter FSM encoding (S_LOW=0, S_RISE_CHK=1, S_HIGH=2, S_FALL_CHK=3)
//           DEBOUNCE_CYCLES_DEFAULT   - 10 ms stability window at 100 MHz
//           LONG_PRESS_CYCLES_DEFAULT - 1 s hold time at 100 MHz
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW      = 2'd0,
    S_RISE_CHK = 2'd1,
    S_HIGH     = 2'd2,
    S_FALL_CHK = 2'd3
  } state_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT   = 1_000_000;
  localparam int LONG_PRESS_CYCLES_DEFAULT = 100_000_000;

endpackage

// File: rtl/sync_ff_chain.sv
// rtl/sync_ff_chain.sv - multi-flop synchroniser for an asynchronous single-bit input
//
// Purpose : brings an asynchronous level into the clk domain through STAGES flops.
// Params  : STAGES - number of flops in the chain (>= 2)
// Ports   : clk   in  system clock
//           reset in  asynchronous active-high reset, clears every stage
//           d     in  asynchronous input
//           q     out synchronised output (last stage)
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - synchronise and debounce a mechanical switch into level and edge pulses
//
// Purpose : conditions the sequencer start switch. The raw pin is synchronised, then a
//           four-state filter only accepts a new level after it has been seen for
//           DEBOUNCE_CYCLES consecutive cycles; any opposite sample restarts the filter.
// Params  : SYNC_STAGES       - synchroniser depth (>= 2)
//           DEBOUNCE_CYCLES   - stable cycles required to accept a change (>= 1)
//           LONG_PRESS_CYCLES - cycles held in the accepted-high state before long_press
// Ports   : clk        in  system clock
//           reset      in  asynchronous active-high reset
//           sw_raw     in  raw switch pin, asynchronous to clk
//           sw_level   out debounced level (registered)
//           sw_rise    out one-cycle pulse on an accepted 0->1 change
//           sw_fall    out one-cycle pulse on an accepted 1->0 change
//           long_press out one-cycle pulse once per sustained press
// Macro   : LONG_PRESS_EN - when defined, builds the hold counter behind long_press;
//           otherwise long_press is tied low and no hold counter exists.
module switch_debounce
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEFAULT,
  parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw,
  output logic sw_level,
  output logic sw_rise,
  output logic sw_fall,
  output logic long_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_in;
  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          level_next, rise_next, fall_next;

  sync_ff_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sw_raw),
    .q     (sync_in)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_LOW;
      cnt      <= '0;
      sw_level <= 1'b0;
      sw_rise  <= 1'b0;
      sw_fall  <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      sw_level <= level_next;
      sw_rise  <= rise_next;
      sw_fall  <= fall_next;
    end
  end

  // The counter is zeroed on every state change so no partial count survives a bounce,
  // and it only advances while below its terminal value so it can never wrap.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    level_next = sw_level;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state)
      S_LOW: begin
        level_next = 1'b0;
        if (sync_in) begin
          state_next = S_RISE_CHK;
          cnt_next   = '0;
        end
      end
      S_RISE_CHK: begin
        level_next = 1'b0;
        if (!sync_in) begin
          state_next = S_LOW;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = S_HIGH;
          cnt_next   = '0;
          level_next = 1'b1;
          rise_next  = 1'b1;
        end else if (cnt < CNT_LAST) begin
          cnt_next = cnt + CW'(1);
        end
      end
      S_HIGH: begin
        level_next = 1'b1;
        if (!sync_in) begin
          state_next = S_FALL_CHK;
          cnt_next   = '0;
        end
      end
      S_FALL_CHK: begin
        level_next = 1'b1;
        if (sync_in) begin
          state_next = S_HIGH;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = S_LOW;
          cnt_next   = '0;
          level_next = 1'b0;
          fall_next  = 1'b1;
        end else if (cnt < CNT_LAST) begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: begin
        state_next = S_LOW;
        cnt_next   = '0;
        level_next = 1'b0;
      end
    endcase
  end

`ifdef LONG_PRESS_EN
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_PRESS_CYCLES);

  logic [HW-1:0] hold, hold_next;
  logic          long_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold       <= '0;
      long_press <= 1'b0;
    end else begin
      hold       <= hold_next;
      long_press <= long_next;
    end
  end

  // Counts only while staying in S_HIGH; any other state (including a dip into
  // S_FALL_CHK) zeroes it, so re-entry to S_HIGH always starts a fresh hold.
  // Parking at HOLD_SAT after the pulse gives exactly one pulse per press.
  always_comb begin
    hold_next = '0;
    long_next = 1'b0;
    if (state == S_HIGH && sync_in) begin
      if (hold < HOLD_LAST) begin
        hold_next = hold + HW'(1);
      end else if (hold == HOLD_LAST) begin
        hold_next = HOLD_SAT;
        long_next = 1'b1;
      end else begin
        hold_next = hold;
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// tb/tb_switch_debounce.sv - self-checking bench for switch_debounce against a run-length reference model
module tb_switch_debounce;

  localparam int S    = 2;
  localparam int D    = 4;
  localparam int LONG = 16;
`ifdef LONG_PRESS_EN
  localparam bit LP = 1'b1;
`else
  localparam bit LP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sw_raw = 1'b0;
  logic sw_level, sw_rise, sw_fall, long_press;

  int checks = 0;
  int failures = 0;

  // Reference model: a delay line for the synchroniser, then a run-length rule
  // (a level is accepted once D+1 consecutive samples disagree with it), and a
  // streak of high samples taken while settled high for the long press.
  logic sync_m [S];
  logic m_level;
  int   run;
  int   streak;
  logic e_rise, e_fall, e_long;

  switch_debounce #(
    .SYNC_STAGES       (S),
    .DEBOUNCE_CYCLES   (D),
    .LONG_PRESS_CYCLES (LONG)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_raw     (sw_raw),
    .sw_level   (sw_level),
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall),
    .long_press (long_press)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] obs();
    return {sw_level, sw_rise, sw_fall, long_press};
  endfunction

  function automatic logic [3:0] exp_vec();
    return {m_level, e_rise, e_fall, LP ? e_long : 1'b0};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < S; i++) sync_m[i] = 1'b0;
    m_level = 1'b0;
    run = 0;
    streak = 0;
    e_rise = 1'b0;
    e_fall = 1'b0;
    e_long = 1'b0;
  endtask

  task automatic model_step();
    logic sample;
    logic settled_high;
    sample = sync_m[S-1];
    for (int i = S - 1; i > 0; i--) sync_m[i] = sync_m[i-1];
    sync_m[0] = sw_raw;
    e_rise = 1'b0;
    e_fall = 1'b0;
    e_long = 1'b0;
    settled_high = m_level && (run == 0);
    if (settled_high && sample) begin
      if (streak < LONG) begin
        streak++;
        e_long = (streak == LONG);
      end
    end else begin
      streak = 0;
    end
    if (sample !== m_level) begin
      run++;
      if (run == D + 1) begin
        m_level = ~m_level;
        run = 0;
        e_rise = m_level;
        e_fall = ~m_level;
      end
    end else begin
      run = 0;
    end
  endtask

  // Drives one input value from a falling edge, lets one rising edge happen,
  // advances the model for that edge and returns on the next falling edge.
  task automatic cycle(input logic raw);
    sw_raw = raw;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic apply_reset(input logic raw);
    @(negedge clk);
    reset = 1'b1;
    sw_raw = raw;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    sw_raw = 1'($urandom_range(0, 1));
    model_reset();
    #12;
    checks++;
    if (obs() !== 4'b0000) begin
      failures++;
      $display("FAIL reset_state outputs=%b required=0000", obs());
    end
    @(negedge clk);
    sw_raw = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_clean_press();
    int rise_edge, rises, long_edge, longs;
    rise_edge = -1; rises = 0; long_edge = -1; longs = 0;
    apply_reset(1'b0);
    repeat (3) cycle(1'b0);
    for (int k = 0; k < 30; k++) begin
      cycle(1'b1);
      checks++;
      if (obs() !== exp_vec()) begin
        failures++;
        $display("FAIL press_edge%0d outputs=%b required=%b", k, obs(), exp_vec());
      end
      if (sw_rise) begin rises++; if (rise_edge < 0) rise_edge = k; end
      if (long_press) begin longs++; if (long_edge < 0) long_edge = k; end
    end
    checks++;
    if (rise_edge != 6 || rises != 1) begin
      failures++;
      $display("FAIL press_rise_edge edge=%0d count=%0d required edge=6 count=1", rise_edge, rises);
    end
    checks++;
    if (LP ? (long_edge != 22 || longs != 1) : (longs != 0)) begin
      failures++;
      $display("FAIL press_long edge=%0d count=%0d required %s", long_edge, longs,
               LP ? "edge=22 count=1" : "count=0");
    end
  endtask

  task automatic test_bounce();
    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int rise_edge, rises;
    rise_edge = -1; rises = 0;
    apply_reset(1'b0);
    repeat (3) cycle(1'b0);
    for (int k = 0; k < 25; k++) begin
      cycle(k < 5 ? pat[k] : 1'b1);
      checks++;
      if (obs() !== exp_vec()) begin
        failures++;
        $display("FAIL bounce_edge%0d outputs=%b required=%b", k, obs(), exp_vec());
      end
      if (sw_rise) begin rises++; if (rise_edge < 0) rise_edge = k; end
    end
    checks++;
    if (rise_edge != 11 || rises != 1) begin
      failures++;
      $display("FAIL bounce_rise edge=%0d count=%0d required edge=11 count=1", rise_edge, rises);
    end
  endtask

  task automatic test_glitch();
    int activity;
    activity = 0;
    apply_reset(1'b0);
    repeat (2) cycle(1'b0);
    for (int k = 0; k < 15; k++) begin
      cycle(k < 3);
      if (obs() !== 4'b0000) activity++;
    end
    checks++;
    if (activity != 0) begin
      failures++;
      $display("FAIL glitch_reject active_cycles=%0d required=0", activity);
    end
  endtask

  task automatic test_release();
    int fall_edge, falls;
    fall_edge = -1; falls = 0;
    apply_reset(1'b1);
    repeat (10) cycle(1'b1);
    // short dip: no fall, long press counting restarts
    for (int k = 0; k < 30; k++) begin
      cycle(!(k < 3));
      checks++;
      if (obs() !== exp_vec()) begin
        failures++;
        $display("FAIL dip_edge%0d outputs=%b required=%b", k, obs(), exp_vec());
      end
      if (sw_fall) falls++;
    end
    checks++;
    if (falls != 0 || sw_level !== 1'b1) begin
      failures++;
      $display("FAIL dip_no_fall falls=%0d level=%b required falls=0 level=1", falls, sw_level);
    end
    for (int k = 0; k < 12; k++) begin
      cycle(1'b0);
      checks++;
      if (obs() !== exp_vec()) begin
        failures++;
        $display("FAIL release_edge%0d outputs=%b required=%b", k, obs(), exp_vec());
      end
      if (sw_fall) begin falls++; if (fall_edge < 0) fall_edge = k; end
    end
    checks++;
    if (fall_edge != 6 || falls != 1 || sw_level !== 1'b0) begin
      failures++;
      $display("FAIL release_fall edge=%0d count=%0d level=%b required edge=6 count=1 level=0",
               fall_edge, falls, sw_level);
    end
  endtask

  task automatic test_reset_mid_filter();
    int rise_edge, rises;
    rise_edge = -1; rises = 0;
    apply_reset(1'b0);
    repeat (2) cycle(1'b0);
    for (int k = 0; k < 5; k++) cycle(1'b1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs() !== 4'b0000) begin
      failures++;
      $display("FAIL midfilter_reset outputs=%b required=0000", obs());
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cycle(1'b1);
      checks++;
      if (obs() !== exp_vec()) begin
        failures++;
        $display("FAIL midfilter_edge%0d outputs=%b required=%b", k, obs(), exp_vec());
      end
      if (sw_rise) begin rises++; if (rise_edge < 0) rise_edge = k; end
    end
    checks++;
    if (rise_edge != 6 || rises != 1) begin
      failures++;
      $display("FAIL midfilter_rise edge=%0d count=%0d required edge=6 count=1", rise_edge, rises);
    end
  endtask

  task automatic test_reset_release_high();
    int rise_edge, rises;
    rise_edge = -1; rises = 0;
    apply_reset(1'b1);
    for (int k = 0; k < 7; k++) cycle(1'b1);
    checks++;
    if (sw_rise !== 1'b1) begin
      failures++;
      $display("FAIL release_high_first_rise sw_rise=%b required=1", sw_rise);
    end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs() !== 4'b0000) begin
      failures++;
      $display("FAIL midpulse_reset outputs=%b required=0000", obs());
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 15; k++) begin
      cycle(1'b1);
      checks++;
      if (obs() !== exp_vec()) begin
        failures++;
        $display("FAIL release_high_edge%0d outputs=%b required=%b", k, obs(), exp_vec());
      end
      if (sw_rise) begin rises++; if (rise_edge < 0) rise_edge = k; end
    end
    checks++;
    if (rise_edge != 6 || rises != 1) begin
      failures++;
      $display("FAIL release_high_rise edge=%0d count=%0d required edge=6 count=1", rise_edge, rises);
    end
  endtask

  task automatic test_random();
    int last_pulse, bad_spacing, k;
    logic lvl;
    last_pulse = -1000; bad_spacing = 0; k = 0; lvl = 1'b0;
    apply_reset(1'b0);
    while (k < 800) begin
      int len;
      lvl = ~lvl;
      len = (($urandom_range(0, 3) == 0) ? $urandom_range(8, 30) : $urandom_range(1, 6));
      for (int j = 0; j < len; j++) begin
        cycle(lvl);
        checks++;
        if (obs() !== exp_vec()) begin
          failures++;
          $display("FAIL random_cyc%0d outputs=%b required=%b", k, obs(), exp_vec());
        end
        if (sw_rise || sw_fall) begin
          if ((sw_rise && sw_fall) || (k - last_pulse < D + 1)) bad_spacing++;
          last_pulse = k;
        end
        k++;
      end
    end
    checks++;
    if (bad_spacing != 0) begin
      failures++;
      $display("FAIL random_pulse_spacing violations=%0d required=0", bad_spacing);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_release();
    test_reset_mid_filter();
    test_reset_release_high();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
